td_reset_seq: RTL

- Parametrised power-up and re-trigger reset sequencer for N_CH external video decoders feeding the BT.656 capture path.
- Generates the timed sequence pre-delay, reset pulse, post-delay, then ready, and can restart it on demand for a selected subset of channels.
- Provides busy, ready and done status to the capture/AST front end, which must hold off until the decoder is ready.

---
 rtl/td_reset_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/td_reset_seq.sv
// Power-up / re-trigger reset sequencer for external video decoders.
// Define TD_RESET_WDOG_EN to add a per-channel sync-loss watchdog retrigger.
module td_reset_seq #(
  parameter int N_CH         = 1,
  parameter int CNT_W        = 20,
  parameter int PRE_CYCLES   = 700000,
  parameter int PULSE_CYCLES = 700000,
  parameter int POST_CYCLES  = 700000,
  parameter int ACTIVE_LOW   = 1,
  parameter int WDOG_CYCLES  = 2000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [N_CH-1:0] ch_mask,
`ifdef TD_RESET_WDOG_EN
  input  logic [N_CH-1:0] sync_seen,
`endif
  output logic [N_CH-1:0] td_rst,
  output logic            busy,
  output logic            ready,
  output logic            done
);

  localparam longint LIM = longint'(1) << CNT_W;

  if (PRE_CYCLES < 1 || longint'(PRE_CYCLES) > LIM ||
      PULSE_CYCLES < 1 || longint'(PULSE_CYCLES) > LIM ||
      POST_CYCLES < 1 || longint'(POST_CYCLES) > LIM ||
      WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("td_reset_seq: illegal cycle parameters");
  end

  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(POST_CYCLES - 1);

  // Deasserted level per pin; XOR with sel gives the asserted pattern.
  localparam logic [N_CH-1:0] OFF = {N_CH{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    S_PRE,
    S_ASSERT,
    S_POST,
    S_READY
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [N_CH-1:0]   sel;
  logic [N_CH-1:0]   sel_n;
  logic              take;
  logic [N_CH-1:0]   take_mask;

`ifdef TD_RESET_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [N_CH-1:0][WD_W-1:0] wcnt;
  logic [N_CH-1:0]           pending;
`endif

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    take      = 1'b0;
    take_mask = ch_mask;
    unique case (state)
      S_PRE:    if (cnt == PRE_LAST) state_n = S_ASSERT;
      S_ASSERT: if (cnt == PULSE_LAST) state_n = S_POST;
      S_POST:   if (cnt == POST_LAST) state_n = S_READY;
      S_READY: begin
        if (start) begin
          take = 1'b1;
`ifdef TD_RESET_WDOG_EN
        end else if (|pending) begin
          take      = 1'b1;
          take_mask = pending;
`endif
        end
      end
      default:  state_n = S_PRE;
    endcase
    if (take) begin
      state_n = S_ASSERT;
      sel_n   = take_mask;
    end
    // cnt is parked at zero in READY so it can never wrap there.
    if (state_n != state || state == S_READY) cnt_n = '0;
    else cnt_n = cnt + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_PRE;
      cnt    <= '0;
      sel    <= '1;
      td_rst <= OFF;
      busy   <= 1'b1;
      ready  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sel    <= sel_n;
      td_rst <= (state_n == S_ASSERT) ? (sel_n ^ OFF) : OFF;
      busy   <= (state_n != S_READY);
      ready  <= (state_n == S_READY);
      done   <= (state_n == S_READY) && (state != S_READY);
    end
  end

`ifdef TD_RESET_WDOG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt    <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync_seen[i] || state != S_READY) wcnt[i] <= '0;
        else if (wcnt[i] != WD_LAST) wcnt[i] <= wcnt[i] + 1'b1;
      end
      if (take) begin
        pending <= '0;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (state == S_READY && sel[i] && wcnt[i] == WD_LAST)
            pending[i] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
